// File: rtl/axi_interconnect_pkg.sv
// Shared interconnect definitions: AXI response encodings, slave port indices
// and a small helper that classifies error responses.
// Ports: none (package).
package axi_interconnect_pkg;

   localparam int unsigned RESP_W = 2;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
   localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      SLV_M00 = 1'b0,
      SLV_M01 = 1'b1
   } slv_idx_e;

   // True for the two error codes; OKAY and EXOKAY are successes.
   function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

   // True for the two success codes.
   function automatic logic resp_is_ok(input logic [RESP_W-1:0] resp);
      return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
   endfunction

endpackage

// File: rtl/wresp_id_fifo.sv
// In-order master-ID tag FIFO for one slave port.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : enqueue a tag (dropped when full with no same-cycle pop)
//   pop           : dequeue the head (ignored when empty)
//   dout          : head entry, combinational from storage
//   full, empty   : registered status derived from the next count
//   ovf           : pulse, a push was dropped this cycle
module wresp_id_fifo #(
   parameter int unsigned DATA_WIDTH = 2,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic                  ovf
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q, empty_q;
   logic                  do_push, do_pop;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop && !empty_q;
      do_push  = push && (!full_q || do_pop);
      ovf      = push && full_q && !do_pop;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // Pointers, count and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == CNT_W'(DEPTH));
         empty_q  <= (count_d == '0);
      end
   end

   // Tag storage needs no reset; occupancy is tracked by the count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/write_resp_channel_arb.sv
// Write-response (B) collector: tags B responses from slave ports M00/M01 with
// the issuing master ID (from per-port in-order ID FIFOs), arbitrates
// round-robin and presents one registered response to the master-side decoder.
// Optional feature macro: WRESP_ERR_CNT_EN adds a saturating 16-bit count of
// SLVERR/DECERR responses on output err_count.
// Ports:
//   ACLK, ARESET                   : clock, synchronous active-high reset
//   Mxx_AXI_bvalid/bresp/bready    : slave-side B channel (bready combinational)
//   Mxx_aw_push/aw_id              : tag push at AW acceptance
//   Mxx_id_full                    : registered ID FIFO full
//   Sel_Resp_ID/Write_Resp/Valid   : registered selected response
//   Sel_Ready                      : downstream accept
//   orphan_err, ovf_err            : sticky error flags
module write_resp_channel_arb
   import axi_interconnect_pkg::*;
#(
   parameter int unsigned Num_Of_Masters  = 4,
   parameter int unsigned Master_ID_Width = $clog2(Num_Of_Masters),
   parameter int unsigned ID_FIFO_DEPTH   = 4
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic                       M00_AXI_bvalid,
   input  logic [1:0]                 M00_AXI_bresp,
   output logic                       M00_AXI_bready,
   input  logic                       M01_AXI_bvalid,
   input  logic [1:0]                 M01_AXI_bresp,
   output logic                       M01_AXI_bready,
   input  logic                       M00_aw_push,
   input  logic [Master_ID_Width-1:0] M00_aw_id,
   output logic                       M00_id_full,
   input  logic                       M01_aw_push,
   input  logic [Master_ID_Width-1:0] M01_aw_id,
   output logic                       M01_id_full,
   output logic [Master_ID_Width-1:0] Sel_Resp_ID,
   output logic [1:0]                 Sel_Write_Resp,
   output logic                       Sel_Valid,
   input  logic                       Sel_Ready,
   output logic                       orphan_err,
   output logic                       ovf_err
`ifdef WRESP_ERR_CNT_EN
   ,
   output logic [15:0]                err_count
`endif
);

   localparam int unsigned ID_W  = Master_ID_Width;
   localparam int unsigned ERR_W = 16;

   logic [ID_W-1:0]   head0, head1;
   logic              empty0, empty1;
   logic              fifo_ovf0, fifo_ovf1;
   logic              elig0, elig1;
   logic              load_en;
   logic              grant_valid;
   slv_idx_e          grant_idx;
   logic [ID_W-1:0]   grant_id;
   logic [1:0]        grant_resp;

   slv_idx_e          last_grant_q, last_grant_d;
   logic              sel_valid_q, sel_valid_d;
   logic [ID_W-1:0]   sel_id_q, sel_id_d;
   logic [1:0]        sel_resp_q, sel_resp_d;
   logic              orphan_q, orphan_d;
   logic              ovf_q, ovf_d;

   wresp_id_fifo #(
      .DATA_WIDTH (ID_W),
      .DEPTH      (ID_FIFO_DEPTH)
   ) u_fifo_m00 (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (M00_aw_push),
      .pop   (M00_AXI_bready),
      .din   (M00_aw_id),
      .dout  (head0),
      .full  (M00_id_full),
      .empty (empty0),
      .ovf   (fifo_ovf0)
   );

   wresp_id_fifo #(
      .DATA_WIDTH (ID_W),
      .DEPTH      (ID_FIFO_DEPTH)
   ) u_fifo_m01 (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (M01_aw_push),
      .pop   (M01_AXI_bready),
      .din   (M01_aw_id),
      .dout  (head1),
      .full  (M01_id_full),
      .empty (empty1),
      .ovf   (fifo_ovf1)
   );

   // Round-robin grant; a port is only eligible once its tag is in the FIFO.
   always_comb begin
      elig0       = M00_AXI_bvalid && !empty0;
      elig1       = M01_AXI_bvalid && !empty1;
      load_en     = !sel_valid_q || Sel_Ready;
      grant_valid = 1'b0;
      grant_idx   = SLV_M00;
      if (load_en) begin
         if (elig0 && elig1) begin
            grant_valid = 1'b1;
            grant_idx   = (last_grant_q == SLV_M00) ? SLV_M01 : SLV_M00;
         end else if (elig0) begin
            grant_valid = 1'b1;
            grant_idx   = SLV_M00;
         end else if (elig1) begin
            grant_valid = 1'b1;
            grant_idx   = SLV_M01;
         end
      end
      M00_AXI_bready = grant_valid && (grant_idx == SLV_M00);
      M01_AXI_bready = grant_valid && (grant_idx == SLV_M01);
      grant_id       = (grant_idx == SLV_M01) ? head1 : head0;
      grant_resp     = (grant_idx == SLV_M01) ? M01_AXI_bresp : M00_AXI_bresp;
   end

   // Output register, arbitration history and sticky flags.
   always_comb begin
      sel_valid_d  = sel_valid_q;
      sel_id_d     = sel_id_q;
      sel_resp_d   = sel_resp_q;
      last_grant_d = last_grant_q;
      if (grant_valid) begin
         sel_valid_d  = 1'b1;
         sel_id_d     = grant_id;
         sel_resp_d   = grant_resp;
         last_grant_d = grant_idx;
      end else if (Sel_Ready) begin
         sel_valid_d  = 1'b0;
      end
      orphan_d = orphan_q | (M00_AXI_bvalid && empty0) | (M01_AXI_bvalid && empty1);
      ovf_d    = ovf_q | fifo_ovf0 | fifo_ovf1;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         sel_valid_q  <= 1'b0;
         sel_id_q     <= '0;
         sel_resp_q   <= RESP_OKAY;
         last_grant_q <= SLV_M01;
         orphan_q     <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         sel_valid_q  <= sel_valid_d;
         sel_id_q     <= sel_id_d;
         sel_resp_q   <= sel_resp_d;
         last_grant_q <= last_grant_d;
         orphan_q     <= orphan_d;
         ovf_q        <= ovf_d;
      end
   end

   assign Sel_Valid      = sel_valid_q;
   assign Sel_Resp_ID    = sel_id_q;
   assign Sel_Write_Resp = sel_resp_q;
   assign orphan_err     = orphan_q;
   assign ovf_err        = ovf_q;

`ifdef WRESP_ERR_CNT_EN
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   // Saturating count of error responses loaded into the output register.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (grant_valid && resp_is_err(grant_resp) && !resp_is_ok(grant_resp) &&
          (err_cnt_q != {ERR_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_write_resp_channel_arb.sv
// Directed bench for write_resp_channel_arb with a queue-based reference model
// checked every cycle plus literal expectations at key points.
module tb_write_resp_channel_arb;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       bv0, bv1;
   logic [1:0] br0, br1;
   logic       push0, push1;
   logic [1:0] id0, id1;
   logic       rdy;

   logic       bready0, bready1, full0, full1;
   logic [1:0] sel_id, sel_resp;
   logic       sel_valid, orphan, ovf;
`ifdef WRESP_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   int vec_cnt  = 0;
   int miss_cnt = 0;

   always #5 clk = ~clk;

   write_resp_channel_arb #(
      .Num_Of_Masters  (4),
      .Master_ID_Width (2),
      .ID_FIFO_DEPTH   (DEPTH)
   ) dut (
      .ACLK           (clk),
      .ARESET         (rst),
      .M00_AXI_bvalid (bv0),
      .M00_AXI_bresp  (br0),
      .M00_AXI_bready (bready0),
      .M01_AXI_bvalid (bv1),
      .M01_AXI_bresp  (br1),
      .M01_AXI_bready (bready1),
      .M00_aw_push    (push0),
      .M00_aw_id      (id0),
      .M00_id_full    (full0),
      .M01_aw_push    (push1),
      .M01_aw_id      (id1),
      .M01_id_full    (full1),
      .Sel_Resp_ID    (sel_id),
      .Sel_Write_Resp (sel_resp),
      .Sel_Valid      (sel_valid),
      .Sel_Ready      (rdy),
      .orphan_err     (orphan),
      .ovf_err        (ovf)
`ifdef WRESP_ERR_CNT_EN
      ,
      .err_count      (err_count)
`endif
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tag queues, a registered response and sticky flags.
   logic [1:0]  mq0[$];
   logic [1:0]  mq1[$];
   logic        m_sv, m_orph, m_ovf;
   logic [1:0]  m_sid, m_sresp;
   int          m_last;
   logic [15:0] m_err;
   bit          seen_rst = 1'b0;

   always @(negedge clk) begin
      bit e0, e1, ld;
      int g, sz0, sz1;
      e0 = bv0 && (mq0.size() > 0);
      e1 = bv1 && (mq1.size() > 0);
      ld = !m_sv || rdy;
      g  = -1;
      if (ld) begin
         if (e0 && e1) g = (m_last == 0) ? 1 : 0;
         else if (e0)  g = 0;
         else if (e1)  g = 1;
      end
      if (seen_rst) begin
         chk("sel_valid", 16'(sel_valid), 16'(m_sv));
         chk("sel_id",    16'(sel_id),    16'(m_sid));
         chk("sel_resp",  16'(sel_resp),  16'(m_sresp));
         chk("bready0",   16'(bready0),   16'(g == 0));
         chk("bready1",   16'(bready1),   16'(g == 1));
         chk("full0",     16'(full0),     16'(mq0.size() == DEPTH));
         chk("full1",     16'(full1),     16'(mq1.size() == DEPTH));
         chk("orphan",    16'(orphan),    16'(m_orph));
         chk("ovf",       16'(ovf),       16'(m_ovf));
`ifdef WRESP_ERR_CNT_EN
         chk("err_count", err_count, m_err);
`endif
      end
      if (rst) begin
         mq0.delete();
         mq1.delete();
         m_sv = 0; m_sid = 0; m_sresp = 0; m_last = 1;
         m_orph = 0; m_ovf = 0; m_err = 0;
         seen_rst = 1'b1;
      end else if (seen_rst) begin
         if ((bv0 && mq0.size() == 0) || (bv1 && mq1.size() == 0)) m_orph = 1;
         sz0 = mq0.size();
         sz1 = mq1.size();
         if (g == 0) begin
            m_sid = mq0.pop_front(); m_sresp = br0; m_sv = 1; m_last = 0;
            if (br0 >= 2'b10 && m_err != 16'hFFFF) m_err++;
         end else if (g == 1) begin
            m_sid = mq1.pop_front(); m_sresp = br1; m_sv = 1; m_last = 1;
            if (br1 >= 2'b10 && m_err != 16'hFFFF) m_err++;
         end else if (rdy) begin
            m_sv = 0;
         end
         if (push0) begin
            if (sz0 == DEPTH && g != 0) m_ovf = 1;
            else mq0.push_back(id0);
         end
         if (push1) begin
            if (sz1 == DEPTH && g != 1) m_ovf = 1;
            else mq1.push_back(id1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bv0 = 0; bv1 = 0; br0 = 0; br1 = 0;
      push0 = 0; push1 = 0; id0 = 0; id1 = 0; rdy = 0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_valid", 16'(sel_valid), 16'h0);
      chk("rst_id",    16'(sel_id),    16'h0);
      chk("rst_full0", 16'(full0),     16'h0);
      chk("rst_orph",  16'(orphan),    16'h0);

      // Single response: tag 2 on M00.
      push0 = 1; id0 = 2; tick(); push0 = 0;
      bv0 = 1; br0 = 2'b00; rdy = 1; #1;
      chk("t1_bready0", 16'(bready0), 16'h1);
      tick(); bv0 = 0;
      chk("t1_valid", 16'(sel_valid), 16'h1);
      chk("t1_id",    16'(sel_id),    16'h2);
      chk("t1_resp",  16'(sel_resp),  16'h0);
      tick();
      chk("t1_drain", 16'(sel_valid), 16'h0);

      // Round-robin alternation, fresh arbitration history.
      do_reset();
      push0 = 1; id0 = 1; push1 = 1; id1 = 0; tick();
      id0 = 3; id1 = 2; tick();
      push0 = 0; push1 = 0;
      bv0 = 1; br0 = 2'b00; bv1 = 1; br1 = 2'b01; rdy = 1;
      tick(); chk("t2_id0", 16'(sel_id), 16'h1);
      tick(); chk("t2_id1", 16'(sel_id), 16'h0); chk("t2_resp1", 16'(sel_resp), 16'h1);
      tick(); chk("t2_id2", 16'(sel_id), 16'h3); bv0 = 0;
      tick(); chk("t2_id3", 16'(sel_id), 16'h2); bv1 = 0;
      chk("t2_orph", 16'(orphan), 16'h0);
      tick();

      // Backpressure: output frozen, pending M01 loads on drain.
      do_reset();
      push0 = 1; id0 = 1; push1 = 1; id1 = 2; tick();
      push0 = 0; push1 = 0;
      bv0 = 1; rdy = 1; tick();
      bv0 = 0; rdy = 0; bv1 = 1; br1 = 2'b10; #1;
      chk("t3_bready1_hold", 16'(bready1), 16'h0);
      tick(); tick();
      chk("t3_hold_valid", 16'(sel_valid), 16'h1);
      chk("t3_hold_id",    16'(sel_id),    16'h1);
      rdy = 1; #1;
      chk("t3_bready1_go", 16'(bready1), 16'h1);
      tick(); bv1 = 0;
      chk("t3_id",   16'(sel_id),   16'h2);
      chk("t3_resp", 16'(sel_resp), 16'h2);
      tick();

      // FIFO full, push+pop while full, dropped push, pointer wrap.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         push0 = 1; id0 = 2'(k); tick();
      end
      chk("t4_full", 16'(full0), 16'h1);
      push0 = 1; id0 = 0; bv0 = 1; br0 = 0; rdy = 1; tick();
      chk("t4_full_pp", 16'(full0), 16'h1);
      chk("t4_ovf0",    16'(ovf),   16'h0);
      chk("t4_id_pp",   16'(sel_id), 16'h0);
      bv0 = 0; push0 = 1; id0 = 1; tick();
      push0 = 0;
      chk("t4_ovf1",  16'(ovf),   16'h1);
      chk("t4_full2", 16'(full0), 16'h1);
      bv0 = 1;
      tick(); chk("t4_d0", 16'(sel_id), 16'h1);
      tick(); chk("t4_d1", 16'(sel_id), 16'h2);
      tick(); chk("t4_d2", 16'(sel_id), 16'h3);
      tick(); chk("t4_d3", 16'(sel_id), 16'h0);
      bv0 = 0; tick();

      // Orphan response on M01, resolved by a later tag push.
      do_reset();
      rdy = 1; bv1 = 1; br1 = 2'b00; #1;
      chk("t5_bready_orph", 16'(bready1), 16'h0);
      tick();
      chk("t5_orph",  16'(orphan),    16'h1);
      chk("t5_valid", 16'(sel_valid), 16'h0);
      push1 = 1; id1 = 3; #1;
      chk("t5_bready_push", 16'(bready1), 16'h0);
      tick(); push1 = 0; #1;
      chk("t5_bready_go", 16'(bready1), 16'h1);
      tick(); bv1 = 0;
      chk("t5_id",    16'(sel_id),    16'h3);
      chk("t5_valid2", 16'(sel_valid), 16'h1);
      tick();

      // Error counting and reset mid-stream.
      do_reset();
      push0 = 1;
      id0 = 0; tick(); id0 = 1; tick(); id0 = 2; tick(); id0 = 3; tick();
      push0 = 0; rdy = 1; bv0 = 1;
      br0 = 2'b10; tick();
      br0 = 2'b11; tick();
      br0 = 2'b00; tick();
`ifdef WRESP_ERR_CNT_EN
      chk("t6_err2", err_count, 16'h2);
`endif
      br0 = 2'b10; rdy = 0; tick();
      chk("t6_valid_pre", 16'(sel_valid), 16'h1);
      rst = 1; tick();
      chk("t6_rst_valid", 16'(sel_valid), 16'h0);
      chk("t6_rst_full",  16'(full0),     16'h0);
`ifdef WRESP_ERR_CNT_EN
      chk("t6_rst_err", err_count, 16'h0);
`endif
      rst = 0; #1;
      chk("t6_rst_bready", 16'(bready0), 16'h0);
      tick(); bv0 = 0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
